// File: rtl/sonar_toggle_rx_pkg.sv
// sonar_toggle_pkg: shared defaults and helpers for the sonar toggle receiver.
//   DEF_DATA_W     - default event word width
//   DEF_FIFO_DEPTH - default number of buffered events (power of two, 2..16)
//   DEF_TS_W       - default timestamp counter width
//   level_w()      - width of the occupancy count for a given FIFO depth
package sonar_toggle_pkg;

    localparam int unsigned DEF_DATA_W     = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 4;
    localparam int unsigned DEF_TS_W       = 32;

    // One extra bit so that a completely full FIFO (level == depth) is representable.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sonar_toggle_rx_if.sv
// sonar_toggle_rx_if: event output stream of the toggle receiver.
//   out_valid - FIFO head holds an event        (master -> slave)
//   out_ready - consumer accepts the head        (slave -> master)
//   out_data  - event word at the FIFO head      (master -> slave)
//   out_ts    - timestamp of the head event      (master -> slave)
interface sonar_toggle_rx_if
    import sonar_toggle_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned TS_W   = DEF_TS_W
) ();

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [TS_W-1:0]   out_ts;

    modport master (output out_valid, output out_data, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ts, output out_ready);

endinterface

// File: rtl/sonar_toggle_rx_edge_sync.sv
// toggle_edge_sync: brings a toggle signal into the clk domain and flags each transition.
//   clk     - receive-domain clock
//   resetn  - asynchronous active-low reset
//   i_tgl   - toggle from the sender domain (asynchronous)
//   o_event - one-cycle pulse per transition of i_tgl, two clk edges after it settles
module toggle_edge_sync (
    input  logic clk,
    input  logic resetn,
    input  logic i_tgl,
    output logic o_event
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // r_s1/r_s2 are the synchronizer pair; r_s3 keeps the previous synchronized value.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_tgl;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign o_event = r_s2 ^ r_s3;

endmodule

// File: rtl/sonar_toggle_rx.sv
// sonar_toggle_rx: receive side of a toggle-handshake event channel with an event FIFO.
//   clk, resetn       - receive clock, asynchronous active-low reset
//   req_tgl, req_data - request toggle and event word from the sender domain
//   ack_tgl           - acknowledge toggle back to the sender
//   out_if (master)   - head-of-FIFO stream: out_valid/out_ready/out_data/out_ts
//   level             - number of buffered events
//   overflow, clr_ovf - sticky drop flag and its clear pulse
// Build option: define SONAR_TOGGLE_RX_TIMESTAMP_EN to timestamp each stored event
// with a free-running TS_W counter; otherwise out_ts is constant 0.
module sonar_toggle_rx
    import sonar_toggle_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned TS_W       = DEF_TS_W
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              req_tgl,
    input  logic [DATA_W-1:0]                 req_data,
    output logic                              ack_tgl,
    sonar_toggle_rx_if.master                 out_if,
    output logic [level_w(FIFO_DEPTH)-1:0]    level,
    output logic                              overflow,
    input  logic                              clr_ovf
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = level_w(FIFO_DEPTH);

    logic             w_event;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             r_ack;
    logic             r_ovf;
    logic [DATA_W-1:0] r_data_mem [FIFO_DEPTH];

    toggle_edge_sync u_sync (
        .clk     (clk),
        .resetn  (resetn),
        .i_tgl   (req_tgl),
        .o_event (w_event)
    );

    // A pop frees the head on the same edge, so a full FIFO can still accept the event.
    always_comb begin
        w_full = (r_level == LVL_W'(FIFO_DEPTH));
        w_pop  = (r_level != '0) && out_if.out_ready;
        w_push = w_event && (!w_full || w_pop);
        w_drop = w_event && w_full && !w_pop;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ack    <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
            // Acknowledge every event, stored or dropped.
            if (w_event) r_ack <= ~r_ack;
            // A drop on the same edge as clr_ovf keeps the flag set.
            if (w_drop)       r_ovf <= 1'b1;
            else if (clr_ovf) r_ovf <= 1'b0;
        end
    end

    // req_data is held stable by the sender until it sees ack, so it is sampled unsynchronized.
    always_ff @(posedge clk) begin
        if (w_push) r_data_mem[r_wr_ptr] <= req_data;
    end

    assign ack_tgl          = r_ack;
    assign level            = r_level;
    assign overflow         = r_ovf;
    assign out_if.out_valid = (r_level != '0);
    // Head contents are masked while empty so reset leaves the outputs at zero.
    assign out_if.out_data  = out_if.out_valid ? r_data_mem[r_rd_ptr] : '0;

`ifdef SONAR_TOGGLE_RX_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts_mem [FIFO_DEPTH];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_ts_cnt <= '0;
        else         r_ts_cnt <= r_ts_cnt + TS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push) r_ts_mem[r_wr_ptr] <= r_ts_cnt;
    end

    assign out_if.out_ts = out_if.out_valid ? r_ts_mem[r_rd_ptr] : '0;
`else
    assign out_if.out_ts = TS_W'(0);
`endif

endmodule
